// File: rtl/onehot_encoder_pkg.sv
// Shared constants and helpers for the streaming one-hot encoder family.
package onehot_encoder_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int unsigned PRIO_LSB = 0;
    localparam int unsigned PRIO_MSB = 1;

    // Callers zero-extend their word to this width before counting.
    localparam int unsigned POP_MAX_W = 256;

    function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < int'(POP_MAX_W); i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority encoder: index of the winning set bit plus zero/multi-hot flags.
module prio_enc_core #(
    parameter int unsigned N        = 8,
    parameter int unsigned W        = $clog2(N),
    parameter int unsigned PRIO_MSB = 0
) (
    input  logic [N-1:0] i_d,
    output logic [W-1:0] o_idx_c,
    output logic         o_zero_c,
    output logic         o_multi_c
);
    import onehot_encoder_pkg::*;

    localparam bit MSB_FIRST = (PRIO_MSB == onehot_encoder_pkg::PRIO_MSB);

    logic [N-1:0] w_low_cleared;

    // Clearing the lowest set bit leaves something only when two or more were set.
    assign w_low_cleared = i_d & (i_d - N'(1));
    assign o_zero_c      = ~|i_d;
    assign o_multi_c     = |w_low_cleared;

    // Last match in scan order wins, so scan direction selects the priority.
    always_comb begin
        o_idx_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (MSB_FIRST) begin
                if (i_d[i]) o_idx_c = W'(i);
            end else if (i_d[int'(N)-1-i]) begin
                o_idx_c = W'(int'(N) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/onehot_encoder_stream.sv
// Streaming one-hot/priority encoder with a 2-entry result buffer and
// saturating error / switching-activity statistics.
module onehot_encoder_stream #(
    parameter int unsigned N        = 8,
    parameter int unsigned W        = $clog2(N),
    parameter int unsigned PRIO_MSB = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic             out_zero,
    output logic             out_multi,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tog_cnt
);
    import onehot_encoder_pkg::*;

    localparam int unsigned RES_W = W + 2;
    localparam int unsigned SUM_W = CNT_W + 33;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [RES_W-1:0] r_ent0;
    logic [RES_W-1:0] r_ent1;
    logic [RES_W-1:0] w_ent0_nxt;
    logic [RES_W-1:0] w_ent1_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [N-1:0]     r_prev_d;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_tog_cnt;

    logic             w_acc;
    logic             w_del;
    logic [W-1:0]     w_idx;
    logic             w_zero;
    logic             w_multi;
    logic [RES_W-1:0] w_res;
    logic [N-1:0]     w_diff;
    logic [31:0]      w_pop;
    logic [SUM_W-1:0] w_tog_sum;
    logic [CNT_W-1:0] w_tog_sat;

    prio_enc_core #(
        .N        (N),
        .W        (W),
        .PRIO_MSB (PRIO_MSB)
    ) u_enc (
        .i_d       (in_d),
        .o_idx_c   (w_idx),
        .o_zero_c  (w_zero),
        .o_multi_c (w_multi)
    );

    assign w_res = {w_idx, w_zero, w_multi};
    assign w_acc = in_valid & r_in_ready;
    assign w_del = r_out_valid & out_ready;

    // Buffer occupancy; entry 0 is always the head presented downstream.
    always_comb begin
        w_state_nxt = r_state;
        w_ent0_nxt  = r_ent0;
        w_ent1_nxt  = r_ent1;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_ent0_nxt  = w_res;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_acc && w_del) begin
                    w_ent0_nxt = w_res;
                end else if (w_acc) begin
                    w_ent1_nxt  = w_res;
                    w_state_nxt = ST_TWO;
                end else if (w_del) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_del) begin
                    w_ent0_nxt = r_ent1;
                    if (w_acc) w_ent1_nxt = w_res;
                    else       w_state_nxt = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_ent0      <= '0;
            r_ent1      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ent0      <= w_ent0_nxt;
            r_ent1      <= w_ent1_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Switching activity against the previously accepted word, clamped at full scale.
    assign w_diff    = in_d ^ r_prev_d;
    assign w_pop     = popcount(POP_MAX_W'(w_diff));
    assign w_tog_sum = SUM_W'(r_tog_cnt) + SUM_W'(w_pop);
    assign w_tog_sat = (w_tog_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_tog_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_err_cnt <= '0;
            r_tog_cnt <= '0;
            r_prev_d  <= '0;
        end else if (w_acc) begin
            if ((w_zero || w_multi) && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            r_tog_cnt <= w_tog_sat;
            r_prev_d  <= in_d;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_ent0[RES_W-1:2];
    assign out_zero  = r_ent0[1];
    assign out_multi = r_ent0[0];
    assign err_cnt   = r_err_cnt;
    assign tog_cnt   = r_tog_cnt;

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Scoreboard bench: LSB-priority, MSB-priority and 4-bit-counter instances share one stimulus stream.
module tb_onehot_encoder_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_d;
    logic       out_ready;
    logic       cnt_clr;

    logic        in_ready, out_valid, out_zero, out_multi;
    logic [2:0]  out_idx;
    logic [15:0] err_cnt, tog_cnt;

    logic        m_in_ready, m_out_valid, m_out_zero, m_out_multi;
    logic [2:0]  m_out_idx;
    logic [15:0] m_err_cnt, m_tog_cnt;

    logic        s_in_ready, s_out_valid, s_out_zero, s_out_multi;
    logic [2:0]  s_out_idx;
    logic [3:0]  s_err_cnt, s_tog_cnt;

    logic [4:0] exp_q[$];
    logic [4:0] exp_m_q[$];
    logic [4:0] mon_e;
    logic [4:0] mon_m_e;

    int checks = 0;
    int errors = 0;

    onehot_encoder_stream #(.N(8), .PRIO_MSB(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_zero(out_zero), .out_multi(out_multi), .cnt_clr(cnt_clr),
        .err_cnt(err_cnt), .tog_cnt(tog_cnt)
    );

    onehot_encoder_stream #(.N(8), .PRIO_MSB(1), .CNT_W(16)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_d(in_d),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx),
        .out_zero(m_out_zero), .out_multi(m_out_multi), .cnt_clr(cnt_clr),
        .err_cnt(m_err_cnt), .tog_cnt(m_tog_cnt)
    );

    onehot_encoder_stream #(.N(8), .PRIO_MSB(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_d(in_d),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_idx(s_out_idx),
        .out_zero(s_out_zero), .out_multi(s_out_multi), .cnt_clr(cnt_clr),
        .err_cnt(s_err_cnt), .tog_cnt(s_tog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation on every delivery.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lsb_unexpected actual=%0h expected=none", {out_idx, out_zero, out_multi});
            end else begin
                mon_e = exp_q.pop_front();
                chk("lsb_result", 32'({out_idx, out_zero, out_multi}), 32'(mon_e));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_out_valid && out_ready) begin
            if (exp_m_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL msb_unexpected actual=%0h expected=none", {m_out_idx, m_out_zero, m_out_multi});
            end else begin
                mon_m_e = exp_m_q.pop_front();
                chk("msb_result", 32'({m_out_idx, m_out_zero, m_out_multi}), 32'(mon_m_e));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] il, input logic [2:0] im,
                        input logic z, input logic m);
        int  n;
        bit  done;
        logic rdy;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_d = d;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back({il, z, m});
                exp_m_q.push_back({im, z, m});
                done = 1;
            end else if (++n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=%0h expected=accepted", d);
                done = 1;
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_m_q.size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_lsb", 32'(exp_q.size()), 32'd0);
        chk("drain_msb", 32'(exp_m_q.size()), 32'd0);
    endtask

    task automatic check_cnts(input int e_err, input int e_tog, input int s_err, input int s_tog);
        @(negedge clk);
        chk("err_cnt", 32'(err_cnt), 32'(e_err));
        chk("tog_cnt", 32'(tog_cnt), 32'(e_tog));
        chk("msb_tog_cnt", 32'(m_tog_cnt), 32'(e_tog));
        chk("sat_err_cnt", 32'(s_err_cnt), 32'(s_err));
        chk("sat_tog_cnt", 32'(s_tog_cnt), 32'(s_tog));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_d = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_multi", 32'(out_multi), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_tog_cnt", 32'(tog_cnt), 32'd0);
        @(posedge clk);
        #1;

        // One-hot sweep, back to back
        for (int i = 0; i < 8; i++) begin
            send(8'(1 << i), 3'(i), 3'(i), 1'b0, 1'b0);
        end
        drain();
        check_cnts(0, 15, 0, 15);

        // Error words
        clear_pulse();
        send(8'h00, 3'd0, 3'd0, 1'b1, 1'b0);
        send(8'h5A, 3'd1, 3'd6, 1'b0, 1'b1);
        drain();
        check_cnts(2, 4, 2, 4);

        // Backpressure: only two taken until the first delivery
        out_ready = 1'b0;
        send(8'h01, 3'd0, 3'd0, 1'b0, 1'b0);
        send(8'h02, 3'd1, 3'd1, 1'b0, 1'b0);
        fork
            send(8'h04, 3'd2, 3'd2, 1'b0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_head_stable", 32'(out_idx), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_back", 32'(in_ready), 32'd1);
            end
        join
        drain();
        check_cnts(2, 13, 2, 13);

        // Saturation of the 4-bit counters
        clear_pulse();
        for (int k = 0; k < 3; k++) begin
            if (k % 2 == 1) send(8'hFF, 3'd0, 3'd7, 1'b0, 1'b1);
            else            send(8'h00, 3'd0, 3'd0, 1'b1, 1'b0);
        end
        check_cnts(3, 16, 3, 15);
        for (int k = 3; k < 16; k++) begin
            if (k % 2 == 1) send(8'hFF, 3'd0, 3'd7, 1'b0, 1'b1);
            else            send(8'h00, 3'd0, 3'd0, 1'b1, 1'b0);
        end
        drain();
        check_cnts(16, 120, 15, 15);

        // Clear coinciding with an accept
        cnt_clr = 1'b1;
        send(8'h0F, 3'd0, 3'd3, 1'b0, 1'b1);
        cnt_clr = 1'b0;
        check_cnts(0, 0, 0, 0);
        send(8'h01, 3'd0, 3'd0, 1'b0, 1'b0);
        drain();
        check_cnts(0, 1, 0, 1);

        // Mid-stream reset with two results buffered
        out_ready = 1'b0;
        send(8'h02, 3'd1, 3'd1, 1'b0, 1'b0);
        send(8'h04, 3'd2, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("mr_full_valid", 32'(out_valid), 32'd1);
        chk("mr_full_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_m_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_err_cnt", 32'(err_cnt), 32'd0);
        chk("mr_tog_cnt", 32'(tog_cnt), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h08, 3'd3, 3'd3, 1'b0, 1'b0);
        drain();
        check_cnts(0, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
